// File: rtl/alu_addsub_acc.sv
// Registered add/subtract/compare unit with an internal accumulator behind a
// valid/ready handshake; result and flags are held until the consumer drains them.
module alu_addsub_acc #(
   parameter int WIDTH    = 8,
   parameter bit SIGNED   = 1'b0,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             ovf,
   output logic             alb,
   output logic             agb,
   output logic             aeb,
   output logic             err,
   output logic [WIDTH-1:0] acc
);

   localparam logic [2:0] OP_ADD     = 3'b000;
   localparam logic [2:0] OP_SUB     = 3'b001;
   localparam logic [2:0] OP_ACC_ADD = 3'b010;
   localparam logic [2:0] OP_ACC_SUB = 3'b011;
   localparam logic [2:0] OP_LOAD    = 3'b100;
   localparam logic [2:0] OP_CLR     = 3'b101;
   localparam logic [2:0] OP_CMP     = 3'b110;

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             c_q, c_d, ovf_q, ovf_d;
   logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             accept_s, sub_s, acc_op_s;
   logic [WIDTH-1:0] x_s, y_s, raw_s, sat_s, arith_s;
   logic [WIDTH:0]   sum_s;
   logic             carry_s, sovf_s, uovf_s, ovf_s;
   logic             lt_s, gt_s, eq_s;

   assign in_ready = ~out_valid_q | out_ready;
   assign accept_s = in_valid & in_ready;

   assign acc_op_s = (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
   assign sub_s    = (op == OP_SUB) || (op == OP_ACC_SUB) || (op == OP_CMP);
   assign x_s      = acc_op_s ? acc_q : a;
   assign y_s      = sub_s ? ~b : b;

   // Subtract is X + ~Y + 1 so c_out doubles as the no-borrow indication.
   assign sum_s   = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, sub_s};
   assign raw_s   = sum_s[WIDTH-1:0];
   assign carry_s = sum_s[WIDTH];
   assign sovf_s  = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (raw_s[WIDTH-1] != x_s[WIDTH-1]);
   assign uovf_s  = sub_s ? ~carry_s : carry_s;
   assign ovf_s   = SIGNED ? sovf_s : uovf_s;
   assign eq_s    = (x_s == b);

   // Clamp value chosen by overflow direction: signed uses X's sign, unsigned uses add/sub.
   always_comb begin
      if (SIGNED) begin
         sat_s = x_s[WIDTH-1] ? SMIN : SMAX;
      end else begin
         sat_s = sub_s ? ZERO : ONES;
      end
      if (SATURATE && ovf_s) begin
         arith_s = sat_s;
      end else begin
         arith_s = raw_s;
      end
   end

   // Magnitude compare of X against the raw operand B, ignoring any clamping.
   always_comb begin
      if (SIGNED && (x_s[WIDTH-1] != b[WIDTH-1])) begin
         lt_s = x_s[WIDTH-1];
         gt_s = b[WIDTH-1];
      end else begin
         lt_s = (x_s < b);
         gt_s = (x_s > b);
      end
   end

   // Next-state selection: load a new result on accept, clear valid on a bare drain.
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      c_d         = c_q;
      ovf_d       = ovf_q;
      lt_d        = lt_q;
      gt_d        = gt_q;
      eq_d        = eq_q;
      err_d       = err_q;
      acc_d       = acc_q;
      if (accept_s) begin
         out_valid_d = 1'b1;
         c_d         = 1'b0;
         ovf_d       = 1'b0;
         lt_d        = lt_s;
         gt_d        = gt_s;
         eq_d        = eq_s;
         err_d       = 1'b0;
         case (op)
            OP_ADD, OP_SUB: begin
               result_d = arith_s;
               c_d      = carry_s;
               ovf_d    = ovf_s;
            end
            OP_ACC_ADD, OP_ACC_SUB: begin
               result_d = arith_s;
               c_d      = carry_s;
               ovf_d    = ovf_s;
               acc_d    = arith_s;
            end
            OP_LOAD: begin
               result_d = a;
               acc_d    = a;
            end
            OP_CLR: begin
               result_d = ZERO;
               acc_d    = ZERO;
            end
            OP_CMP: begin
               result_d = raw_s;
               c_d      = carry_s;
               ovf_d    = ovf_s;
            end
            default: begin
               result_d = ZERO;
               lt_d     = 1'b0;
               gt_d     = 1'b0;
               eq_d     = 1'b0;
               err_d    = 1'b1;
            end
         endcase
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output and accumulator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= ZERO;
         c_q         <= 1'b0;
         ovf_q       <= 1'b0;
         lt_q        <= 1'b0;
         gt_q        <= 1'b0;
         eq_q        <= 1'b0;
         err_q       <= 1'b0;
         acc_q       <= ZERO;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         c_q         <= c_d;
         ovf_q       <= ovf_d;
         lt_q        <= lt_d;
         gt_q        <= gt_d;
         eq_q        <= eq_d;
         err_q       <= err_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign c_out     = c_q;
   assign ovf       = ovf_q;
   assign alb       = lt_q;
   assign agb       = gt_q;
   assign aeb       = eq_q;
   assign err       = err_q;
   assign acc       = acc_q;

endmodule

// File: tb/tb_alu_addsub_acc.sv
// Bench for alu_addsub_acc: four instances (every SIGNED/SATURATE combination) share
// one stimulus stream and are checked against an integer-arithmetic reference model.
module tb_alu_addsub_acc;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, out_ready;
   logic [2:0] op;
   logic [7:0] a, b;

   logic [3:0]      d_rdy, d_valid, d_c, d_ovf, d_lt, d_gt, d_eq, d_err;
   logic [3:0][7:0] d_res, d_acc;

   always #5 clk = ~clk;

   // Config index c: SIGNED = c%2, SATURATE = c/2.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      alu_addsub_acc #(.WIDTH(8), .SIGNED((g % 2) == 1), .SATURATE(g >= 2)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_rdy[g]),
         .op(op), .a(a), .b(b), .out_valid(d_valid[g]), .out_ready(out_ready),
         .result(d_res[g]), .c_out(d_c[g]), .ovf(d_ovf[g]), .alb(d_lt[g]),
         .agb(d_gt[g]), .aeb(d_eq[g]), .err(d_err[g]), .acc(d_acc[g])
      );
   end

   int n_vec = 0;
   int n_miss = 0;

   logic       m_valid;
   logic [7:0] m_res[4], m_acc[4];
   logic       m_c[4], m_ovf[4], m_lt[4], m_gt[4], m_eq[4], m_err[4];

   typedef struct {
      int         cfg;
      logic [2:0] op;
      logic [7:0] a, b, res;
      logic       c, ov, lt, gt, eq, er;
      logic [7:0] acc;
   } vec_t;
   vec_t tv[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         m_res[c] = 8'h00; m_acc[c] = 8'h00; m_c[c] = 1'b0; m_ovf[c] = 1'b0;
         m_lt[c] = 1'b0; m_gt[c] = 1'b0; m_eq[c] = 1'b0; m_err[c] = 1'b0;
      end
   endtask

   // Reference: true mathematical sum/difference, then range-check against the mode's limits.
   task automatic model_op(input int c);
      int sg, st, xu, yu, xs, ys, tr, lo, hi;
      logic [7:0] x;
      sg = c % 2;
      st = c / 2;
      x  = (op == 3'd2 || op == 3'd3) ? m_acc[c] : a;
      xu = int'(x);
      yu = int'(b);
      xs = (sg == 1 && xu > 127) ? xu - 256 : xu;
      ys = (sg == 1 && yu > 127) ? yu - 256 : yu;
      lo = (sg == 1) ? -128 : 0;
      hi = (sg == 1) ? 127 : 255;
      m_lt[c] = (xs < ys); m_gt[c] = (xs > ys); m_eq[c] = (xs == ys);
      m_err[c] = 1'b0; m_c[c] = 1'b0; m_ovf[c] = 1'b0;
      case (op)
         3'd0, 3'd1, 3'd2, 3'd3, 3'd6: begin
            if (op == 3'd0 || op == 3'd2) begin
               tr = xs + ys;
               m_c[c] = ((xu + yu) > 255);
            end else begin
               tr = xs - ys;
               m_c[c] = (xu >= yu);
            end
            m_ovf[c] = (tr > hi) || (tr < lo);
            if (st == 1 && m_ovf[c] && op != 3'd6) tr = (tr > hi) ? hi : lo;
            m_res[c] = tr[7:0];
            if (op == 3'd2 || op == 3'd3) m_acc[c] = tr[7:0];
         end
         3'd4: begin m_res[c] = a; m_acc[c] = a; end
         3'd5: begin m_res[c] = 8'h00; m_acc[c] = 8'h00; end
         default: begin
            m_res[c] = 8'h00; m_lt[c] = 1'b0; m_gt[c] = 1'b0; m_eq[c] = 1'b0; m_err[c] = 1'b1;
         end
      endcase
   endtask

   task automatic model_edge();
      if (in_valid && (!m_valid || out_ready)) begin
         for (int c = 0; c < 4; c++) model_op(c);
         m_valid = 1'b1;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_model(input string nm);
      logic [23:0] act, exp;
      for (int c = 0; c < 4; c++) begin
         act = {d_valid[c], d_rdy[c], d_c[c], d_ovf[c], d_lt[c], d_gt[c], d_eq[c], d_err[c], d_res[c], d_acc[c]};
         exp = {m_valid, (!m_valid || out_ready), m_c[c], m_ovf[c], m_lt[c], m_gt[c], m_eq[c], m_err[c], m_res[c], m_acc[c]};
         chk($sformatf("%s cfg%0d", nm, c), {8'h00, act}, {8'h00, exp});
      end
   endtask

   task automatic cycle(input string nm);
      @(posedge clk);
      model_edge();
      #1;
      check_model(nm);
   endtask

   task automatic tab_chk(input int i, input string nm);
      int c;
      c = tv[i].cfg;
      chk($sformatf("%s%0d valid", nm, i), {31'd0, d_valid[c]}, 32'd1);
      chk($sformatf("%s%0d c/ovf/lt/gt/eq/err/res/acc", nm, i),
          {10'd0, d_c[c], d_ovf[c], d_lt[c], d_gt[c], d_eq[c], d_err[c], d_res[c], d_acc[c]},
          {10'd0, tv[i].c, tv[i].ov, tv[i].lt, tv[i].gt, tv[i].eq, tv[i].er, tv[i].res, tv[i].acc});
   endtask

   initial begin
      //                 cfg op    a      b      res    c     ov    lt    gt    eq    err   acc
      tv.push_back(vec_t'{0, 3'd0, 8'h3F, 8'h3E, 8'h7D, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{0, 3'd1, 8'h3F, 8'h3F, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
      tv.push_back(vec_t'{0, 3'd1, 8'h3F, 8'h40, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{0, 3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{1, 3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{3, 3'd0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{2, 3'd0, 8'hFF, 8'h01, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{1, 3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{3, 3'd1, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{2, 3'd1, 8'h10, 8'h20, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{0, 3'd6, 8'h05, 8'h09, 8'hFC, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      tv.push_back(vec_t'{0, 3'd4, 8'h10, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10});
      tv.push_back(vec_t'{0, 3'd2, 8'h00, 8'h05, 8'h15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h15});
      tv.push_back(vec_t'{0, 3'd3, 8'h00, 8'h20, 8'hF5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF5});
      tv.push_back(vec_t'{0, 3'd5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
      tv.push_back(vec_t'{0, 3'd7, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
      tv.push_back(vec_t'{0, 3'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
      model_reset();
      #12;
      check_model("reset");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tv[i]) begin
         in_valid = 1'b1; out_ready = 1'b1; op = tv[i].op; a = tv[i].a; b = tv[i].b;
         cycle("tab");
         tab_chk(i, "tab");
         in_valid = 1'b0; out_ready = 1'b0;
         cycle("tab_hold");
         tab_chk(i, "tab_hold");
         out_ready = 1'b1;
         cycle("tab_drain");
      end

      // Back-pressure: a pending ACC_ADD must not be taken while the consumer stalls.
      in_valid = 1'b1; out_ready = 1'b1; op = 3'd0; a = 8'h05; b = 8'h06;
      cycle("bp_accept");
      op = 3'd2; b = 8'h33; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle("bp_hold");
         chk("bp_in_ready", {31'd0, d_rdy[0]}, 32'd0);
         chk("bp_result", {24'd0, d_res[0]}, 32'h0B);
         chk("bp_acc", {24'd0, d_acc[0]}, 32'h00);
      end
      out_ready = 1'b1;
      cycle("b2b_1");
      chk("b2b_1 result", {24'd0, d_res[0]}, 32'h33);
      op = 3'd0; a = 8'h20; b = 8'h22;
      cycle("b2b_2");
      chk("b2b_2 valid", {31'd0, d_valid[0]}, 32'd1);
      chk("b2b_2 result", {24'd0, d_res[0]}, 32'h42);
      in_valid = 1'b0;
      cycle("bp_drain");
      chk("bp_drain valid", {31'd0, d_valid[0]}, 32'd0);

      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         op = 3'($urandom_range(0, 7));
         a  = 8'($urandom);
         b  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80;
         if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h01;
         cycle("rnd");
      end

      // Reset while a result is held: everything clears without waiting for a clock.
      in_valid = 1'b1; out_ready = 1'b0; op = 3'd4; a = 8'hA5; b = 8'h00;
      cycle("pre_rst");
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_model("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("post_rst");

      in_valid = 1'b1; out_ready = 1'b1; op = 3'd7; a = 8'h55; b = 8'h66;
      cycle("reserved");
      chk("reserved err", {31'd0, d_err[0]}, 32'd1);
      op = 3'd0; a = 8'h01; b = 8'h01;
      cycle("err_clear");
      chk("err_clear err", {31'd0, d_err[0]}, 32'd0);
      in_valid = 1'b0;
      cycle("final_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
